control_multiciclo: RTL and testbench

CONTROL_MULTICICLO -- requirements
Module: control_multiciclo

---
 rtl/control_pkg.sv | 38 +++
 rtl/control_decode.sv | 29 ++
 rtl/control_multiciclo.sv | 88 ++++++++
 tb/tb_control_multiciclo.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared constants for the multicycle controller: opcode and ALU codes,
// state encoding and the decoded-instruction record.
package control_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_TER  = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_TER  = 4'b0111;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_SW,
    CLS_LW,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_e;

  typedef struct packed {
    op_class_e  cls;
    logic [3:0] alu;
    logic       legal;
  } decode_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder: opcode -> {class, ALU code, legal}.
// LW is decoded only when CONTROL_MULTICICLO_LW_EN is defined.
module control_decode
  import control_pkg::*;
#(
  parameter int OPCODE_W = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  output decode_t             dec
);

  // Constants are widened so any nonzero upper opcode bit falls to default.
  always_comb begin
    // NOTE: default assignment first so every path drives dec (no latch).
    dec = '{cls: CLS_ILLEGAL, alu: ALU_NONE, legal: 1'b0};
    case (opcode)
      OPCODE_W'(OP_ADD):  dec = '{cls: CLS_ALU,  alu: ALU_ADD,  legal: 1'b1};
      OPCODE_W'(OP_SUB):  dec = '{cls: CLS_ALU,  alu: ALU_SUB,  legal: 1'b1};
      OPCODE_W'(OP_TER):  dec = '{cls: CLS_ALU,  alu: ALU_TER,  legal: 1'b1};
      OPCODE_W'(OP_SW):   dec = '{cls: CLS_SW,   alu: ALU_NONE, legal: 1'b1};
`ifdef CONTROL_MULTICICLO_LW_EN
      OPCODE_W'(OP_LW):   dec = '{cls: CLS_LW,   alu: ALU_NONE, legal: 1'b1};
`endif
      OPCODE_W'(OP_HALT): dec = '{cls: CLS_HALT, alu: ALU_NONE, legal: 1'b1};
      default:            dec = '{cls: CLS_ILLEGAL, alu: ALU_NONE, legal: 1'b0};
    endcase
  end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle Moore control unit: IDLE -> DECODE -> EXEC/MEM -> WB -> IDLE, HALT absorbing.
// Define CONTROL_MULTICICLO_LW_EN to compile in the LW (memory load) path.
module control_multiciclo
  import control_pkg::*;
#(
  parameter int OPCODE_W = 3,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                instr_ready,
  input  logic                mem_ready,
  output logic                we_br,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                sel_demux,
  output logic                we_mem,
  output logic                re_mem,
  output logic                busy,
  output logic                illegal_op,
  output logic                halted
);

  logic [2:0]          state, state_d;
  logic [OPCODE_W-1:0] opcode_q;
  logic                illegal_q;
  decode_t             dec;
  logic                is_lw;

  control_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode (opcode_q),
    .dec    (dec)
  );

`ifdef CONTROL_MULTICICLO_LW_EN
  assign is_lw = (dec.cls == CLS_LW);
`else
  assign is_lw = 1'b0;
`endif

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (instr_valid) state_d = S_DECODE;
      S_DECODE: begin
        case (dec.cls)
          CLS_ALU:       state_d = S_EXEC;
          CLS_SW,
          CLS_LW:        state_d = S_MEM;
          CLS_HALT:      state_d = S_HALT;
          default:       state_d = S_IDLE;
        endcase
      end
      S_EXEC:   state_d = S_WB;
      S_MEM:    if (mem_ready) state_d = is_lw ? S_WB : S_IDLE;
      S_WB:     state_d = S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_d;
      illegal_q <= (state == S_DECODE) && !dec.legal;
      if (state == S_IDLE && instr_valid) opcode_q <= opcode;
    end
  end

  // Outputs depend on registered state only, so reset clears them at once.
  assign instr_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign halted      = (state == S_HALT);
  assign illegal_op  = illegal_q;
  assign we_br       = (state == S_WB);
  assign we_mem      = (state == S_MEM) && (dec.cls == CLS_SW);
  assign re_mem      = (state == S_MEM) && is_lw;
  assign sel_demux   = (state == S_MEM) || ((state == S_WB) && is_lw);
  assign alu_op      = ((state == S_EXEC) || ((state == S_WB) && (dec.cls == CLS_ALU)))
                       ? ALU_OP_W'(dec.alu) : '0;

endmodule

// File: tb/tb_control_multiciclo.sv
// Randomized self-checking bench for control_multiciclo; expected per-cycle
// output traces are built per instruction from the opcode table and wait count.
module tb_control_multiciclo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [2:0] opcode;
  logic       instr_ready;
  logic       mem_ready;
  logic       we_br;
  logic [3:0] alu_op;
  logic       sel_demux;
  logic       we_mem;
  logic       re_mem;
  logic       busy;
  logic       illegal_op;
  logic       halted;

  int n_checks = 0;
  int n_errors = 0;

  control_multiciclo #(.OPCODE_W(3), .ALU_OP_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .instr_ready (instr_ready),
    .mem_ready   (mem_ready),
    .we_br       (we_br),
    .alu_op      (alu_op),
    .sel_demux   (sel_demux),
    .we_mem      (we_mem),
    .re_mem      (re_mem),
    .busy        (busy),
    .illegal_op  (illegal_op),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Observed vector: {instr_ready, we_br, alu_op[3:0], sel_demux, we_mem, re_mem, busy, illegal_op, halted}
  logic [11:0] obs;
  assign obs = {instr_ready, we_br, alu_op, sel_demux, we_mem, re_mem, busy, illegal_op, halted};

  function automatic logic [11:0] mk(logic rdy, logic wbr, logic [3:0] alu, logic sel,
                                     logic wm, logic rm, logic bsy, logic ill, logic hlt);
    return {rdy, wbr, alu, sel, wm, rm, bsy, ill, hlt};
  endfunction

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (rdy,we_br,alu[4],sel,we_mem,re_mem,busy,ill,halt) t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Called at posedge+1 with inputs already set: check mid-cycle, then cross the edge.
  task automatic step(input logic [11:0] e, input string tag);
    @(negedge clk);
    check(tag, obs, e);
    @(posedge clk);
    #1;
  endtask

  // Reference instruction table.
  localparam int K_ALU = 0, K_SW = 1, K_LW = 2, K_HALT = 3, K_ILL = 4;

  function automatic int kind_of(logic [2:0] op);
    case (op)
      3'd0, 3'd1, 3'd2: return K_ALU;
      3'd3:             return K_SW;
`ifdef CONTROL_MULTICICLO_LW_EN
      3'd4:             return K_LW;
`endif
      3'd7:             return K_HALT;
      default:          return K_ILL;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(logic [2:0] op);
    case (op)
      3'd0:    return 4'b0010;
      3'd1:    return 4'b0110;
      3'd2:    return 4'b0111;
      default: return 4'b0000;
    endcase
  endfunction

  logic [11:0] idle_o;
  logic [11:0] busy_o;
  assign idle_o = mk(1, 0, 4'd0, 0, 0, 0, 0, 0, 0);
  assign busy_o = mk(0, 0, 4'd0, 0, 0, 0, 1, 0, 0);

  // Entered at posedge+1; leaves with reset released before the next edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_async"}, obs, idle_o);
    @(posedge clk);
    #1;
    check({tag, "_held"}, obs, idle_o);
    rst_n = 1'b1;
  endtask

  task automatic run_op(input logic [2:0] op, input int waits);
    int k;
    logic [3:0] a;
    k = kind_of(op);
    a = alu_of(op);
    instr_valid = 1'b1;
    opcode      = op;
    mem_ready   = 1'($urandom);
    step(idle_o, "accept");
    instr_valid = 1'b0;
    opcode      = 3'($urandom);
    mem_ready   = 1'($urandom);
    step(busy_o, "decode");
    case (k)
      K_ALU: begin
        step(mk(0, 0, a, 0, 0, 0, 1, 0, 0), "exec");
        mem_ready = 1'($urandom);
        step(mk(0, 1, a, 0, 0, 0, 1, 0, 0), "wb_alu");
      end
      K_SW, K_LW: begin
        for (int i = 0; i <= waits; i++) begin
          mem_ready = (i == waits);
          step(mk(0, 0, 4'd0, 1, k == K_SW, k == K_LW, 1, 0, 0), "mem");
        end
        if (k == K_LW) begin
          mem_ready = 1'($urandom);
          step(mk(0, 1, 4'd0, 1, 0, 0, 1, 0, 0), "wb_lw");
        end
      end
      K_ILL: step(mk(1, 0, 4'd0, 0, 0, 0, 0, 1, 0), "ill_pulse");
      default: begin
        instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
          opcode    = 3'($urandom);
          mem_ready = 1'($urandom);
          step(mk(0, 0, 4'd0, 0, 0, 0, 1, 0, 1), "halted");
        end
        instr_valid = 1'b0;
        do_reset("halt_rst");
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    opcode      = '0;
    mem_ready   = 1'b0;
    #1;
    check("reset_state", obs, idle_o);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_op(3'd0, 0);   // ADD latency
    run_op(3'd3, 5);   // SW with 5 stalled cycles
    run_op(3'd4, 3);   // LW, or illegal without the LW path
    run_op(3'd5, 0);   // illegal opcode

    // Reset while stalled in MEM drops we_mem without a clock edge.
    instr_valid = 1'b1;
    opcode      = 3'd3;
    step(idle_o, "rm_accept");
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    step(busy_o, "rm_decode");
    step(mk(0, 0, 4'd0, 1, 1, 0, 1, 0, 0), "rm_mem");
    check("rm_mem_live", obs, mk(0, 0, 4'd0, 1, 1, 0, 1, 0, 0));
    do_reset("mem_rst");

    run_op(3'd7, 0);   // HALT, then reset
    run_op(3'd1, 0);

    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        instr_valid = 1'b0;
        mem_ready   = 1'($urandom);
        step(idle_o, "gap");
      end
      run_op(3'($urandom_range(0, 7)), int'($urandom_range(0, 6)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
